vector_wb_stage: RTL and testbench

//  Writeback stage directly downstream of vector_alu.

---
 rtl/vector_wb_stage.sv | 147 ++++++++++++++
 tb/tb_vector_wb_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_wb_stage.sv
// Vector writeback stage: buffers ALU results in a 2-entry FIFO and drains each one
// into the vector register file a few lanes per cycle, then commits the flags.
module vector_wb_stage #(
  parameter int WIDTH          = 24,
  parameter int VECTOR_WIDTH   = 8,
  parameter int LANES_PER_BEAT = 2,
  parameter int NUM_VREGS      = 8,
  localparam int VW    = $clog2(NUM_VREGS),
  localparam int BEATS = VECTOR_WIDTH / LANES_PER_BEAT,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]    in_data,
  input  logic [3:0]                            in_flags,
  input  logic [VW-1:0]                         in_vd,
  input  logic                                  in_we,
  output logic                                  vrf_we,
  output logic [VW-1:0]                         vrf_addr,
  output logic [BW-1:0]                         vrf_beat,
  output logic [LANES_PER_BEAT*WIDTH-1:0]       vrf_wdata,
  output logic [3:0]                            flags_q,
  output logic                                  done,
  output logic                                  busy
);

  typedef struct packed {
    logic [VECTOR_WIDTH-1:0][WIDTH-1:0] data;
    logic [3:0]                         flags;
    logic [VW-1:0]                      vd;
    logic                               we;
  } entry_t;

  typedef enum logic {IDLE, WRITE} state_e;

  entry_t        fifo_q [2];
  entry_t        fifo_d [2];
  logic          rd_ptr_q, rd_ptr_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic [1:0]    count_q, count_d;
  state_e        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [3:0]    flags_d;
  logic          push, pop;
  entry_t        head, next_entry;
  logic [BEATS-1:0][LANES_PER_BEAT*WIDTH-1:0] head_beats;

  assign in_ready   = (count_q != 2'd2);
  assign push       = in_valid && in_ready;
  assign head       = fifo_q[rd_ptr_q];
  assign next_entry = fifo_q[~rd_ptr_q];
  assign busy       = (count_q != 2'd0) || (state_q != IDLE);

  // Regrouping the lane vector into beats keeps lane 0 in the LSBs of beat 0.
  assign head_beats = head.data;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{data: in_data, flags: in_flags, vd: in_vd, we: in_we};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    flags_d   = flags_q;
    pop       = 1'b0;
    done      = 1'b0;
    vrf_we    = 1'b0;
    vrf_addr  = '0;
    vrf_beat  = '0;
    vrf_wdata = '0;
    unique case (state_q)
      IDLE: begin
        if (count_q != 2'd0) begin
          if (head.we) begin
            state_d = WRITE;
            beat_d  = '0;
          end else begin
            done    = 1'b1;
            flags_d = head.flags;
            pop     = 1'b1;
          end
        end
      end
      WRITE: begin
        vrf_we    = 1'b1;
        vrf_addr  = head.vd;
        vrf_beat  = beat_q;
        vrf_wdata = head_beats[beat_q];
        if (beat_q != BW'(BEATS - 1)) begin
          beat_d = beat_q + BW'(1);
        end else begin
          done    = 1'b1;
          flags_d = head.flags;
          pop     = 1'b1;
          beat_d  = '0;
          // Only an entry already stored behind the head can continue without a gap.
          if (count_q == 2'd2 && next_entry.we) begin
            state_d = WRITE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      flags_q  <= 4'h0;
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_vector_wb_stage.sv
// Randomised scoreboard bench for vector_wb_stage: expected VRF beats and retire
// flags are queued on acceptance and checked by an independent monitor.
module tb_vector_wb_stage;

  localparam int WIDTH        = 24;
  localparam int VECTOR_WIDTH = 8;
  localparam int LPB          = 2;
  localparam int NUM_VREGS    = 8;
  localparam int VW           = 3;
  localparam int BEATS        = 4;
  localparam int BW           = 2;

  logic                               clk;
  logic                               rst;
  logic                               in_valid;
  logic                               in_ready;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] in_data;
  logic [3:0]                         in_flags;
  logic [VW-1:0]                      in_vd;
  logic                               in_we;
  logic                               vrf_we;
  logic [VW-1:0]                      vrf_addr;
  logic [BW-1:0]                      vrf_beat;
  logic [LPB*WIDTH-1:0]               vrf_wdata;
  logic [3:0]                         flags_q;
  logic                               done;
  logic                               busy;

  vector_wb_stage #(
    .WIDTH(WIDTH), .VECTOR_WIDTH(VECTOR_WIDTH), .LANES_PER_BEAT(LPB), .NUM_VREGS(NUM_VREGS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_flags(in_flags), .in_vd(in_vd), .in_we(in_we),
    .vrf_we(vrf_we), .vrf_addr(vrf_addr), .vrf_beat(vrf_beat), .vrf_wdata(vrf_wdata),
    .flags_q(flags_q), .done(done), .busy(busy)
  );

  typedef struct {
    logic [VW-1:0]        addr;
    logic [BW-1:0]        beat;
    logic [LPB*WIDTH-1:0] wdata;
  } write_t;

  write_t     exp_writes[$];
  logic [3:0] exp_done[$];
  write_t     mon_w;
  logic [3:0] model_flags = 4'h0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_beat_cyc = -1;
  int done_cyc = -1;
  int done_count = 0;
  int write_count = 0;
  int run_len = 0;
  int max_run = 0;

  logic [WIDTH-1:0] lanes_v [VECTOR_WIDTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle compares the DUT's write port and retire pulses against the queues.
  always @(negedge clk) begin
    if (rst) begin
      exp_writes.delete();
      exp_done.delete();
      model_flags = 4'h0;
      run_len     = 0;
    end else begin
      check_output("flags_q_track", {60'd0, flags_q}, {60'd0, model_flags});
      if (vrf_we) begin
        write_count++;
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (vrf_beat == '0) first_beat_cyc = cyc;
        if (exp_writes.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr=%0d beat=%0d, required no write", vrf_addr, vrf_beat);
        end else begin
          mon_w = exp_writes.pop_front();
          check_output("vrf_addr", {61'd0, vrf_addr}, {61'd0, mon_w.addr});
          check_output("vrf_beat", {62'd0, vrf_beat}, {62'd0, mon_w.beat});
          check_output("vrf_wdata", {16'd0, vrf_wdata}, {16'd0, mon_w.wdata});
        end
      end else begin
        run_len = 0;
        check_output("idle_vrf_outputs", {11'd0, vrf_addr, vrf_beat, vrf_wdata}, 64'd0);
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done=1, required 0 (cycle %0d)", cyc);
        end else begin
          model_flags = exp_done.pop_front();
        end
      end
    end
  end

  // Drives one entry until accepted; expectations are queued from the lane array directly.
  task automatic apply_stimulus(input logic [WIDTH-1:0] lanes [VECTOR_WIDTH], input logic [VW-1:0] vd,
                                input logic [3:0] flags, input logic we, input bit hold,
                                output int acc_cyc);
    bit     rdy;
    int     t;
    write_t w;
    for (int l = 0; l < VECTOR_WIDTH; l++) in_data[l] = lanes[l];
    in_vd    = vd;
    in_flags = flags;
    in_we    = we;
    in_valid = 1'b1;
    acc_cyc  = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rdy = in_ready;
      t   = cyc;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_cyc = t;
        break;
      end
    end
    if (acc_cyc < 0) begin
      check_output("accept_timeout", 64'd0, 64'd1);
    end else begin
      if (we) begin
        for (int b = 0; b < BEATS; b++) begin
          w.addr  = vd;
          w.beat  = BW'(b);
          w.wdata = '0;
          for (int l = 0; l < LPB; l++) w.wdata[l*WIDTH +: WIDTH] = lanes[b*LPB + l];
          exp_writes.push_back(w);
        end
      end
      exp_done.push_back(flags);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (exp_writes.size() == 0 && exp_done.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check_output("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_lanes();
    for (int l = 0; l < VECTOR_WIDTH; l++) lanes_v[l] = WIDTH'($urandom);
  endtask

  initial begin
    int ta, tb, tc, d0, w0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_flags = 4'h0;
    in_vd = '0;
    in_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check_output("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check_output("reset_vrf_we", {63'd0, vrf_we}, 64'd0);
    check_output("reset_flags_q", {60'd0, flags_q}, 64'd0);
    check_output("reset_busy", {63'd0, busy}, 64'd0);
    check_output("reset_done", {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] single write entry");
    for (int l = 0; l < VECTOR_WIDTH; l++) lanes_v[l] = WIDTH'(l + 1);
    d0 = done_count;
    apply_stimulus(lanes_v, 3'd3, 4'b0100, 1'b1, 1'b0, ta);
    wait_drain();
    check_output("first_beat_latency", 64'(first_beat_cyc), 64'(ta + 2));
    check_output("write_done_latency", 64'(done_cyc), 64'(ta + 1 + BEATS));
    check_output("write_done_pulses", 64'(done_count - d0), 64'd1);
    check_output("flags_after_write", {60'd0, flags_q}, {60'd0, 4'b0100});

    $display("[TB] flags-only entry");
    d0 = done_count;
    w0 = write_count;
    randomize_lanes();
    apply_stimulus(lanes_v, 3'd5, 4'b1001, 1'b0, 1'b0, ta);
    wait_drain();
    check_output("flags_only_done_latency", 64'(done_cyc), 64'(ta + 1));
    check_output("flags_only_no_write", 64'(write_count - w0), 64'd0);
    check_output("flags_after_flags_only", {60'd0, flags_q}, {60'd0, 4'b1001});

    $display("[TB] three back-to-back writes");
    d0 = done_count;
    max_run = 0;
    randomize_lanes();
    apply_stimulus(lanes_v, 3'd1, 4'b0001, 1'b1, 1'b1, ta);
    randomize_lanes();
    apply_stimulus(lanes_v, 3'd2, 4'b0010, 1'b1, 1'b1, tb);
    randomize_lanes();
    apply_stimulus(lanes_v, 3'd5, 4'b1010, 1'b1, 1'b0, tc);
    wait_drain();
    check_output("second_accept_cycle", 64'(tb), 64'(ta + 1));
    check_output("third_accept_cycle", 64'(tc), 64'(ta + BEATS + 2));
    check_output("gapless_write_run", 64'(max_run), 64'(3 * BEATS));
    check_output("burst_done_pulses", 64'(done_count - d0), 64'd3);

    $display("[TB] reset during beat 2");
    randomize_lanes();
    apply_stimulus(lanes_v, 3'd6, 4'b0010, 1'b1, 1'b0, ta);
    repeat (3) @(posedge clk);
    #1;
    check_output("pre_reset_beat", {61'd0, vrf_we, vrf_beat}, {61'd0, 1'b1, 2'd2});
    rst = 1'b1;
    d0 = done_count;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    w0 = write_count;
    check_output("abort_vrf_we", {63'd0, vrf_we}, 64'd0);
    check_output("abort_busy", {63'd0, busy}, 64'd0);
    check_output("abort_flags_q", {60'd0, flags_q}, 64'd0);
    check_output("abort_done", {63'd0, done}, 64'd0);
    check_output("abort_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check_output("abort_no_more_writes", 64'(write_count - w0), 64'd0);
    check_output("abort_no_done", 64'(done_count - d0), 64'd0);

    $display("[TB] all-ones entry");
    for (int l = 0; l < VECTOR_WIDTH; l++) lanes_v[l] = {WIDTH{1'b1}};
    apply_stimulus(lanes_v, 3'd7, 4'b1111, 1'b1, 1'b0, ta);
    wait_drain();
    check_output("flags_all_ones", {60'd0, flags_q}, {60'd0, 4'b1111});

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      bit hold;
      randomize_lanes();
      hold = ($urandom_range(0, 1) == 1);
      apply_stimulus(lanes_v, VW'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), hold, ta);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    wait_drain();
    check_output("random_queues_empty", 64'(exp_writes.size() + exp_done.size()), 64'd0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
